// File: rtl/ex_mem_stage_pkg.sv
// Shared definitions for the EX/MEM stage: op codes, access-size decode and alignment check.
package ex_mem_stage_pkg;

    localparam int unsigned OP_CODE_W = 8;
    typedef logic [OP_CODE_W-1:0] op_code_t;

    localparam op_code_t OP_NOP = 8'h00;
    localparam op_code_t OP_LB  = 8'h01;
    localparam op_code_t OP_LH  = 8'h02;
    localparam op_code_t OP_LW  = 8'h03;
    localparam op_code_t OP_LBU = 8'h04;
    localparam op_code_t OP_LHU = 8'h05;
    localparam op_code_t OP_SB  = 8'h06;
    localparam op_code_t OP_SH  = 8'h07;
    localparam op_code_t OP_SW  = 8'h08;
    localparam op_code_t OP_LD  = 8'h09;
    localparam op_code_t OP_SD  = 8'h0A;

    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESULT} state_e;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} acc_size_e;

    typedef struct packed {
        logic      is_mem;
        logic      is_load;
        logic      is_signed;
        acc_size_e size;
    } op_dec_t;

    // has_d enables the doubleword ops, which exist only on 64-bit datapaths
    function automatic op_dec_t decode_op(input op_code_t op, input logic has_d);
        op_dec_t d;
        d.is_mem    = 1'b0;
        d.is_load   = 1'b0;
        d.is_signed = 1'b0;
        d.size      = SZ_B;
        case (op)
            OP_LB:  begin d.is_mem = 1'b1; d.is_load = 1'b1; d.is_signed = 1'b1; end
            OP_LBU: begin d.is_mem = 1'b1; d.is_load = 1'b1; end
            OP_LH:  begin d.is_mem = 1'b1; d.is_load = 1'b1; d.is_signed = 1'b1; d.size = SZ_H; end
            OP_LHU: begin d.is_mem = 1'b1; d.is_load = 1'b1; d.size = SZ_H; end
            OP_LW:  begin d.is_mem = 1'b1; d.is_load = 1'b1; d.is_signed = 1'b1; d.size = SZ_W; end
            OP_SB:  begin d.is_mem = 1'b1; end
            OP_SH:  begin d.is_mem = 1'b1; d.size = SZ_H; end
            OP_SW:  begin d.is_mem = 1'b1; d.size = SZ_W; end
            OP_LD:  begin d.is_mem = has_d; d.is_load = has_d; d.size = SZ_D; end
            OP_SD:  begin d.is_mem = has_d; d.size = SZ_D; end
            default: ;
        endcase
        return d;
    endfunction

    function automatic logic is_aligned(input acc_size_e sz, input logic [2:0] off);
        case (sz)
            SZ_B:    return 1'b1;
            SZ_H:    return (off[0] == 1'b0);
            SZ_W:    return (off[1:0] == 2'b00);
            default: return (off == 3'b000);
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store byte enables / replicated write data, and load lane extraction with extension.
module mem_lane_align
    import ex_mem_stage_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  acc_size_e         st_size_i,
    input  logic [2:0]        st_off_i,
    input  logic [XLEN-1:0]   st_data_i,
    output logic [XLEN/8-1:0] be_o,
    output logic [XLEN-1:0]   wdata_o,
    input  acc_size_e         ld_size_i,
    input  logic [2:0]        ld_off_i,
    input  logic              ld_signed_i,
    input  logic [XLEN-1:0]   ld_rdata_i,
    output logic [XLEN-1:0]   ld_data_o
);

    localparam int unsigned NB = XLEN / 8;

    logic [7:0]  size_mask;
    int unsigned lane_mask;

    // store side: size mask shifted to the byte offset, source lanes repeated across the word
    always_comb begin
        size_mask = 8'h01;
        lane_mask = 0;
        case (st_size_i)
            SZ_B:    begin size_mask = 8'h01; lane_mask = 0; end
            SZ_H:    begin size_mask = 8'h03; lane_mask = 1; end
            SZ_W:    begin size_mask = 8'h0F; lane_mask = 3; end
            default: begin size_mask = 8'hFF; lane_mask = 7; end
        endcase
        be_o    = NB'(size_mask) << st_off_i;
        wdata_o = '0;
        for (int i = 0; i < NB; i++) begin
            wdata_o[i*8 +: 8] = st_data_i[(i & lane_mask)*8 +: 8];
        end
    end

    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] keep;
    logic            sign_bit;

    // load side: bring the addressed lane to bit 0, then mask and optionally sign-fill
    always_comb begin
        shifted  = ld_rdata_i >> {ld_off_i, 3'b000};
        keep     = '1;
        sign_bit = 1'b0;
        case (ld_size_i)
            SZ_B:    begin keep = XLEN'(64'hFF);        sign_bit = shifted[7];      end
            SZ_H:    begin keep = XLEN'(64'hFFFF);      sign_bit = shifted[15];     end
            SZ_W:    begin keep = XLEN'(64'hFFFF_FFFF); sign_bit = shifted[31];     end
            default: begin keep = '1;                   sign_bit = shifted[XLEN-1]; end
        endcase
        ld_data_o = (shifted & keep) | ((ld_signed_i && sign_bit) ? ~keep : '0);
    end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with a req/ack data-memory access, timeout and squash handling.
module ex_mem_stage
    import ex_mem_stage_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned OPW     = 4,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OPW-1:0]    doing_op,
    input  logic [31:0]       instr,
    input  logic [XLEN-1:0]   aluo,
    input  logic [XLEN-1:0]   b,
    input  logic              flush,
    output logic              mem_req,
    output logic              mem_we,
    output logic [XLEN/8-1:0] mem_be,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_ack,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              wb_valid,
    output logic [XLEN-1:0]   aluo_ex_mem,
    output logic [XLEN-1:0]   rdata_ex_mem,
    output logic [31:0]       instr_ex_mem,
    output logic [OPW-1:0]    doing_op_ex_mem,
    output logic              err_misalign,
    output logic              err_bus
);

    localparam int unsigned NB   = XLEN / 8;
    localparam int unsigned OFFW = $clog2(NB);
    localparam int unsigned CNTW = $clog2(TIMEOUT + 1);

    state_e            state_q, state_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic              squash_q, squash_d;
    logic              in_ready_q, in_ready_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [NB-1:0]     mem_be_q, mem_be_d;
    logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
    logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
    logic              wb_valid_q, wb_valid_d;
    logic [XLEN-1:0]   aluo_q, aluo_d;
    logic [XLEN-1:0]   rdata_q, rdata_d;
    logic [31:0]       instr_q, instr_d;
    logic [OPW-1:0]    op_q, op_d;
    op_dec_t           dec_q, dec_d;
    logic              err_mis_q, err_mis_d;
    logic              err_bus_q, err_bus_d;

    op_dec_t         in_dec;
    logic [2:0]      in_off;
    logic [2:0]      hold_off;
    logic [NB-1:0]   st_be;
    logic [XLEN-1:0] st_wdata;
    logic [XLEN-1:0] ld_data;
    logic            accept;

    assign in_dec   = decode_op(OP_CODE_W'(doing_op), (XLEN == 64));
    assign in_off   = 3'(aluo[OFFW-1:0]);
    assign hold_off = 3'(aluo_q[OFFW-1:0]);

    mem_lane_align #(.XLEN(XLEN)) u_lane (
        .st_size_i   (in_dec.size),
        .st_off_i    (in_off),
        .st_data_i   (b),
        .be_o        (st_be),
        .wdata_o     (st_wdata),
        .ld_size_i   (dec_q.size),
        .ld_off_i    (hold_off),
        .ld_signed_i (dec_q.is_signed),
        .ld_rdata_i  (mem_rdata),
        .ld_data_o   (ld_data)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        squash_d    = squash_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        wb_valid_d  = 1'b0;
        aluo_d      = aluo_q;
        rdata_d     = rdata_q;
        instr_d     = instr_q;
        op_d        = op_q;
        dec_d       = dec_q;
        err_mis_d   = err_mis_q;
        err_bus_d   = err_bus_q;
        accept      = in_valid && in_ready_q && !flush;

        case (state_q)
            ST_ACCESS: begin
                if (flush) begin
                    squash_d = 1'b1;
                end
                // an ack in the final wait cycle still wins over the timeout
                if (mem_ack || (cnt_q == CNTW'(TIMEOUT - 1))) begin
                    mem_req_d = 1'b0;
                    cnt_d     = '0;
                    squash_d  = 1'b0;
                    if (squash_q || flush) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d    = ST_RESULT;
                        wb_valid_d = 1'b1;
                        err_bus_d  = !mem_ack;
                        rdata_d    = (mem_ack && dec_q.is_mem && dec_q.is_load) ? ld_data : '0;
                    end
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                if (accept) begin
                    op_d      = doing_op;
                    instr_d   = instr;
                    aluo_d    = aluo;
                    dec_d     = in_dec;
                    err_mis_d = 1'b0;
                    err_bus_d = 1'b0;
                    rdata_d   = '0;
                    if (in_dec.is_mem && is_aligned(in_dec.size, in_off)) begin
                        state_d     = ST_ACCESS;
                        mem_req_d   = 1'b1;
                        mem_we_d    = !in_dec.is_load;
                        mem_be_d    = st_be;
                        mem_addr_d  = {aluo[XLEN-1:OFFW], OFFW'(0)};
                        mem_wdata_d = st_wdata;
                        cnt_d       = '0;
                        squash_d    = 1'b0;
                    end else begin
                        state_d    = ST_RESULT;
                        wb_valid_d = 1'b1;
                        err_mis_d  = in_dec.is_mem;
                    end
                end
            end
        endcase

        in_ready_d = (state_d != ST_ACCESS);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            squash_q    <= 1'b0;
            in_ready_q  <= 1'b1;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            wb_valid_q  <= 1'b0;
            aluo_q      <= '0;
            rdata_q     <= '0;
            instr_q     <= '0;
            op_q        <= '0;
            dec_q       <= '0;
            err_mis_q   <= 1'b0;
            err_bus_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            squash_q    <= squash_d;
            in_ready_q  <= in_ready_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            wb_valid_q  <= wb_valid_d;
            aluo_q      <= aluo_d;
            rdata_q     <= rdata_d;
            instr_q     <= instr_d;
            op_q        <= op_d;
            dec_q       <= dec_d;
            err_mis_q   <= err_mis_d;
            err_bus_q   <= err_bus_d;
        end
    end

    assign in_ready        = in_ready_q;
    assign mem_req         = mem_req_q;
    assign mem_we          = mem_we_q;
    assign mem_be          = mem_be_q;
    assign mem_addr        = mem_addr_q;
    assign mem_wdata       = mem_wdata_q;
    assign wb_valid        = wb_valid_q;
    assign aluo_ex_mem     = aluo_q;
    assign rdata_ex_mem    = rdata_q;
    assign instr_ex_mem    = instr_q;
    assign doing_op_ex_mem = op_q;
    assign err_misalign    = err_mis_q;
    assign err_bus         = err_bus_q;

endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

Parametrised EX/MEM pipeline stage that registers the execute-stage result and runs the data-memory access for loads and stores. It supports byte, halfword and word accesses with byte enables, sign/zero extension and misalignment detection. Memory is reached over a req/ack handshake with a timeout. The block sits between the ALU stage and MEM/WB and back-pressures the pipeline while an access is outstanding.

## Interface
Parameters:
- XLEN, 32, data and address width; must be 32 or 64
- OPW, 4, width of the `doing_op` field
- TIMEOUT, 15, maximum cycles to wait for `mem_ack` before reporting a bus error; must be ≥ 1

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- in_valid  in  1  EX presents an operation
- in_ready  out  1  stage can accept this cycle
- doing_op  in  OPW  operation code
- instr  in  32  instruction word, passed through
- aluo  in  XLEN  ALU result, used as the effective address for memory ops
- b  in  XLEN  store data source
- flush  in  1  synchronous squash of the held operation
- mem_req  out  1  access request
- mem_we  out  1  1 for store, 0 for load
- mem_be  out  XLEN/8  byte enables
- mem_addr  out  XLEN  word-aligned address
- mem_wdata  out  XLEN  store data, lane-shifted
- mem_ack  in  1  access complete; `mem_rdata` is valid in the same cycle
- mem_rdata  in  XLEN  raw read word
- wb_valid  out  1  result is valid for MEM/WB, one-cycle pulse
- aluo_ex_mem  out  XLEN  registered ALU result
- rdata_ex_mem  out  XLEN  extended load data; 0 for non-loads
- instr_ex_mem  out  32  registered instruction word
- doing_op_ex_mem  out  OPW  registered operation code
- err_misalign  out  1  valid with `wb_valid`
- err_bus  out  1  valid with `wb_valid`

## Operation
- The stage has 3 states: IDLE, ACCESS, RESULT.
- Accept condition: `in_valid && in_ready && !flush`.
- `in_ready` = 1 in IDLE and in RESULT, 0 in ACCESS.
- On accept, the stage latches `doing_op`, `instr`, `aluo` and `b`.
- Next state after accept:
  - Memory op that is aligned → ACCESS.
  - Non-memory op, or memory op that is misaligned → RESULT.
- ACCESS:
  - Drive `mem_req` = 1 with stable `mem_we`, `mem_be`, `mem_addr` and `mem_wdata` until `mem_ack`.
  - On `mem_ack`, capture the extended `rdata` and go to RESULT.
  - A wait counter counts cycles spent in ACCESS. If it reaches TIMEOUT without `mem_ack`: drop `mem_req`, set `err_bus`, go to RESULT.
- RESULT:
  - `wb_valid` = 1 for exactly one cycle.
  - Next state: ACCESS or RESULT if a new op is accepted in the same cycle, otherwise IDLE.
- Memory ops are `lb`, `lbu`, `lh`, `lhu`, `lw`, `sb`, `sh`, `sw`, plus `ld`/`sd` when XLEN=64.
- Alignment: halfword requires addr[0]=0; word requires addr[1:0]=0; doubleword requires addr[2:0]=0.
- A misaligned op issues no request. It reaches RESULT with `err_misalign` = 1 and `rdata_ex_mem` = 0.
- `mem_addr` = `aluo` with its low log2(XLEN/8) bits cleared.
- `mem_be`: access-size mask shifted left by the byte offset.
- `mem_wdata`: `b` replicated across all lanes.
- Load data: select the lane by byte offset. `lb`/`lh` (and `lw` when XLEN=64) sign-extend; `lbu`/`lhu` zero-extend.
- flush:
  - In IDLE or RESULT: no accept occurs, `wb_valid` is 0 next cycle, and the stage goes to IDLE.
  - In ACCESS: `mem_req` is held until `mem_ack` or timeout. The completion is discarded (no `wb_valid`) and the stage goes to IDLE.
  - A flush in ACCESS is remembered in a sticky squash bit until completion.
- Registered outputs hold their values while idle. Only `wb_valid` qualifies them.

## Timing
- Reset (asynchronous): state IDLE, counter and squash bit 0, every output 0, except `in_ready` = 1.
- Non-memory op accepted at edge N → `wb_valid` high in cycle N+1. Back-to-back issue gives 1 op/cycle.
- Memory op accepted at edge N:
  - `mem_req` is high in cycle N+1.
  - `mem_ack` in cycle N+k → `wb_valid` in cycle N+k+1.
  - Zero-wait memory (ack in N+1) therefore gives `wb_valid` in N+2.
- `mem_ack` outside ACCESS is ignored.
- `mem_ack` arriving in the same cycle the wait counter reaches TIMEOUT counts as success; `err_bus` = 0.
- Reset asserted mid-ACCESS: `mem_req` drops immediately; any outstanding ack is ignored.

## Structure
- Op-code defines (`lb` … `sd`), access-size decode and the alignment function go in the shared `def.v`. Reuse the existing `lw`/`sw` codes there.
- The FSM and the wait counter stay in `ex_mem_stage`.
- One natural sub-module: `mem_lane_align`. It is combinational and does `be`/`wdata` generation and load extraction/extension. Both directions are parametrised by XLEN.

## Test plan
- XLEN=32: non-memory op followed immediately by another non-memory op, `aluo`=0x1234 → `wb_valid` in consecutive cycles; `aluo_ex_mem`=0x1234; `mem_req` never asserted.
- `sb` with addr 0x103, `b`=0xAB → `mem_be`=4'b1000, `mem_addr`=0x100, `mem_wdata`=0xABABABAB. Ack after 3 cycles → `wb_valid` 1 cycle later.
- `lb` addr 0x102, `mem_rdata`=0x00800000 → `rdata_ex_mem`=0xFFFFFF80. Same access with `lbu` → 0x00000080.
- `lw` addr 0x102 → no `mem_req`; `wb_valid` next cycle with `err_misalign`=1.
- No ack, TIMEOUT=15 → `mem_req` high for exactly 15 cycles, then `wb_valid` with `err_bus`=1. `in_ready` stays 0 throughout.
- flush during ACCESS, ack 2 cycles later → no `wb_valid`; IDLE. Async reset mid-access → `mem_req`=0 in the same cycle.
